// File: rtl/saph_float_stepper.sv
// saph_float_stepper
// Multi-channel floating-point stepper for the rasterizer. Each channel holds
// a running float value. A latch loads the init values. Each count pulse
// queues one step, and a queued step adds (or subtracts) the channel increment
// using one external fixed-latency FP adder per channel. Every channel is
// independent of the others and has at most one add in flight.
//
// Ports:
//   clk       core clock
//   rst       synchronous reset, active-low
//   latch     load init into all channels, discard queued and in-flight steps
//   count     per-channel step request (one step per cycle high)
//   dir       per-channel direction, 0 = add inc, 1 = subtract inc
//   init      initial values, channel c at [c*WIDTH +: WIDTH]
//   inc       increment values, same packing
//   cur       current values, same packing
//   ready     no steps pending or in flight on any channel
//   ovf       sticky per-channel flag: a count pulse was dropped (queue full)
//   add_trig  per-channel adder start
//   add_lhs   adder left operand (current value)
//   add_rhs   adder right operand (increment, sign flipped when dir=1)
//   add_res   adder result, valid LATENCY cycles after add_trig
module saph_float_stepper #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 32,
  parameter int LATENCY     = 3,
  parameter int MAX_PENDING = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      latch,
  input  logic [CHANNELS-1:0]       count,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS*WIDTH-1:0] init,
  input  logic [CHANNELS*WIDTH-1:0] inc,
  output logic [CHANNELS*WIDTH-1:0] cur,
  output logic                      ready,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       add_trig,
  output logic [CHANNELS*WIDTH-1:0] add_lhs,
  output logic [CHANNELS*WIDTH-1:0] add_rhs,
  input  logic [CHANNELS*WIDTH-1:0] add_res
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [CHANNELS-1:0] idle;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [PW-1:0]      pend_q, pend_d;
    logic [LATENCY-1:0] infl_q, infl_d;
    logic               ovf_q, ovf_d;
    logic               busy, issue, room, acc;

    always_comb begin
      busy  = |infl_q;
      issue = !busy && (pend_q != '0) && !latch && rst;
      // An issue frees a slot at the same edge, so a full queue still
      // accepts a pulse in the issue cycle.
      room  = (pend_q < PW'(MAX_PENDING)) || issue;
      acc   = count[c] && !latch && room;

      cur_d  = cur_q;
      pend_d = pend_q + PW'(acc) - PW'(issue);
      // Bit k set means an add issued k+1 edges ago; the top bit marks the
      // cycle in which the adder result is valid.
      infl_d = (infl_q << 1) | LATENCY'(issue);
      ovf_d  = ovf_q | (count[c] && !latch && !room);

      if (infl_q[LATENCY-1]) begin
        cur_d = add_res[c*WIDTH +: WIDTH];
      end

      if (latch) begin
        cur_d  = init[c*WIDTH +: WIDTH];
        pend_d = '0;
        infl_d = '0;
        ovf_d  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cur_q  <= '0;
        pend_q <= '0;
        infl_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        cur_q  <= cur_d;
        pend_q <= pend_d;
        infl_q <= infl_d;
        ovf_q  <= ovf_d;
      end
    end

    assign cur[c*WIDTH +: WIDTH]     = cur_q;
    assign ovf[c]                    = ovf_q;
    assign add_trig[c]               = issue;
    assign add_lhs[c*WIDTH +: WIDTH] = cur_q;
    assign add_rhs[c*WIDTH +: WIDTH] = {inc[c*WIDTH + WIDTH - 1] ^ (dir[c] & issue),
                                        inc[c*WIDTH +: WIDTH-1]};
    assign idle[c]                   = !busy && (pend_q == '0);
  end

  assign ready = &idle;

endmodule

// File: doc/saph_float_stepper.md
Name: saph_float_stepper

Overview:
Parametrised multi-channel floating-point stepper for the rasterizer: holds CHANNELS running float values (edge functions, interpolants), loads them from init values and advances each by a per-channel increment using one external fixed-latency FP adder per channel. Successor of the two-float incrementer. Adds:
- per-channel step queueing (multiple count pulses while an add is in flight);
- per-channel direction (add or subtract);
- overflow flags;
- a global ready.

Parameters:
CHANNELS, 2, number of independent float channels (>=1)
WIDTH, 32, float width in bits; sign is bit WIDTH-1
LATENCY, 3, adder latency in cycles from trig to valid result (>=1)
MAX_PENDING, 3, maximum queued steps per channel (>=1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
latch  in  1  load init into all channels; overrides count
count  in  CHANNELS  per-channel step request, one step per cycle high
dir  in  CHANNELS  per-channel direction: 0 = add inc, 1 = subtract inc
init  in  CHANNELS*WIDTH  initial values, channel c at [c*WIDTH +: WIDTH]
inc  in  CHANNELS*WIDTH  increment values, same packing
cur  out  CHANNELS*WIDTH  current values, same packing
ready  out  1  no steps pending or in flight on any channel
ovf  out  CHANNELS  sticky: a count pulse was dropped because the queue was full
add_trig  out  CHANNELS  adder start, one per channel
add_lhs  out  CHANNELS*WIDTH  adder left operand
add_rhs  out  CHANNELS*WIDTH  adder right operand
add_res  in  CHANNELS*WIDTH  adder result, valid exactly LATENCY cycles after add_trig

Behaviour:
- Reset (rst=0 at posedge): cur=0, pending=0, in-flight tracking cleared, ovf=0, add_trig=0, ready=1. Adder results arriving after reset are ignored.
- Per-channel state:
  - pending counter, width clog2(MAX_PENDING+1);
  - LATENCY-deep in-flight shift register;
  - busy = OR of the shift register.
- Latch (rst=1, latch=1):
  - cur[c] <= init[c] for all c; pending <= 0; in-flight cleared; ovf <= 0; add_trig=0 that cycle.
  - Results of in-flight adds are discarded.
  - count is ignored in the same cycle.
- Count accept: count[c]=1 and latch=0.
  - If pending<MAX_PENDING, pending increments; otherwise the pulse is dropped and ovf[c] <= 1.
- Issue (combinational): channel c issues when busy=0, pending>0, latch=0 and rst=1.
  - add_trig[c]=1, add_lhs[c]=cur[c], add_rhs[c]=inc[c] with the sign bit XOR dir[c].
  - inc and dir are sampled in the issue cycle.
  - pending decrements at that edge.
  - Accept and issue in the same cycle leave pending unchanged, so a full queue still accepts in that cycle.
- Writeback: LATENCY cycles after issue, cur[c] <= add_res[c] and busy clears at that edge. The earliest next issue is the following cycle, so lhs always sees the updated value.
- Throughput: one step per LATENCY+1 cycles per channel. Channels are fully independent.
- When not issuing: add_lhs = cur, add_rhs = inc, add_trig=0.
- ready = AND over c of (busy=0 and pending=0). It is combinational from registered state: high the cycle after a latch, low the cycle after any accepted count until the final writeback edge.
- Special values: no special handling of NaN/Inf; the adder result is stored verbatim.

Test Plan:
- Reset/latch: reset, then latch with init0=0x3F800000 (1.0), init1=0x40000000 (2.0) -> cur0=0x3F800000, cur1=0x40000000, ready=1, add_trig=0 after the edge.
- Single step: LATENCY=3, inc0=0x3F000000 (0.5), one count0 pulse -> add_trig0 high one cycle after the pulse edge; cur0=0x3FC00000 (1.5) exactly 3 cycles later; ready low throughout, high afterwards; cur1 unchanged.
- Queue and subtract: count1 high 3 consecutive cycles, dir1=1, inc1=0x3F800000 -> three issues spaced 4 cycles apart; cur1 goes 2.0 -> 1.0 -> 0.0 (0x00000000) -> -1.0 (0xBF800000); ovf1=0.
- Overflow: MAX_PENDING=3, count0 high 6 cycles starting from idle -> 1 issued, 3 queued, excess pulses dropped; ovf0=1; cur0 advances by exactly the accepted step count; ovf0 clears on the next latch.
- Latch mid-operation: latch one cycle after add_trig0 -> cur0=init0; the late add_res is not written; ready=1 the next cycle; add_trig stays low.
- Reset mid-operation: rst=0 during an in-flight add with pending=2 -> cur=0, ready=1, ovf=0; no add_trig and no writeback after reset deasserts.
